// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: bus-select decode, memory read handshake with timeout,
// IR load strobe, execute hand-off and PC advance. Optional macro FETCH_SEQ_SINGLE_STEP_EN adds a step input.
module fetch_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic       mem_ack,
  input  logic [3:0] opcode,
  input  logic       exec_done,
  output logic [1:0] bus_sel,
  output logic       mem_re,
  output logic       ir_load,
  output logic       exec_start,
  output logic       pc_inc,
  output logic       halted,
  output logic       fetch_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_LOAD   = 3'd3,
    S_DECODE = 3'd4,
    S_EXEC   = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_PC   = 2'b01;
  localparam logic [1:0] BUS_MEM  = 2'b10;
  localparam logic [1:0] BUS_EXU  = 2'b11;

  // Last WAIT count value; failing to see ack on it means timeout.
  localparam logic [TW-1:0] CNT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        cur, nxt;
  logic [TW-1:0] cnt;
  logic          start, resume;

`ifdef FETCH_SEQ_SINGLE_STEP_EN
  // Each step pulse admits one instruction; completion always parks in IDLE.
  assign start  = step;
  assign resume = 1'b0;
`else
  assign start  = run;
  assign resume = run;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur <= S_IDLE;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_ADDR)
        cnt <= '0;
      else if (cur == S_WAIT && !mem_ack)
        cnt <= cnt + TW'(1);
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (start) nxt = S_ADDR;
      S_ADDR:   nxt = S_WAIT;
      // Ack on the final count still wins over the timeout.
      S_WAIT:   if (mem_ack) nxt = S_LOAD;
                else if (cnt == CNT_LAST) nxt = S_ERR;
      S_LOAD:   nxt = S_DECODE;
      S_DECODE: nxt = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
      S_EXEC:   if (exec_done) nxt = resume ? S_ADDR : S_IDLE;
      S_HALT:   if (!run) nxt = S_IDLE;
      S_ERR:    nxt = S_ERR;
      default:  nxt = S_IDLE;
    endcase
  end

  // Outputs decode from state; pc_inc and exec_start also qualify on the
  // same-cycle exec_done / opcode so the PC moves with instruction completion.
  always_comb begin
    bus_sel    = BUS_NONE;
    mem_re     = 1'b0;
    ir_load    = 1'b0;
    exec_start = 1'b0;
    pc_inc     = 1'b0;
    halted     = 1'b0;
    fetch_err  = 1'b0;
    case (cur)
      S_ADDR:   begin bus_sel = BUS_PC;  mem_re = 1'b1; end
      S_WAIT:   begin bus_sel = BUS_MEM; mem_re = 1'b1; end
      S_LOAD:   begin bus_sel = BUS_MEM; ir_load = 1'b1; end
      S_DECODE: exec_start = (opcode != HALT_OPCODE);
      S_EXEC:   begin bus_sel = BUS_EXU; pc_inc = exec_done; end
      S_HALT:   halted = 1'b1;
      S_ERR:    fetch_err = 1'b1;
      default:  bus_sel = BUS_NONE;
    endcase
  end

  assign state = cur;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: normal fetch, halt, timeout, late ack,
// run drop, async reset abort, and single-step when FETCH_SEQ_SINGLE_STEP_EN is defined.
module tb_fetch_sequencer;
  logic       clk, reset, run, mem_ack, exec_done;
  logic [3:0] opcode;
  logic [1:0] bus_sel;
  logic       mem_re, ir_load, exec_start, pc_inc, halted, fetch_err;
  logic [2:0] state;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
  logic       step;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_ir   = 0;
  int n_pc   = 0;
  int n_es   = 0;
  int b_ir, b_pc, b_es;

  fetch_sequencer #(.MEM_TIMEOUT(15), .HALT_OPCODE(4'hF), .TW(8)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_ack(mem_ack), .opcode(opcode), .exec_done(exec_done),
    .bus_sel(bus_sel), .mem_re(mem_re), .ir_load(ir_load), .exec_start(exec_start),
    .pc_inc(pc_inc), .halted(halted), .fetch_err(fetch_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the active edge (pre-update values).
  always @(posedge clk) begin
    if (ir_load)    n_ir <= n_ir + 1;
    if (pc_inc)     n_pc <= n_pc + 1;
    if (exec_start) n_es <= n_es + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    b_ir = n_ir; b_pc = n_pc; b_es = n_es;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; opcode = 4'h1;
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    // Reset state
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_outs", {bus_sel, mem_re, ir_load, exec_start, pc_inc, halted, fetch_err}, 0);
    reset = 1'b1;
    tick();
    chk("idle_hold", state, 0);

`ifndef FETCH_SEQ_SINGLE_STEP_EN
    // Normal fetch: 1,2,3,4,5,5,5,1
    snap();
    run = 1'b1;
    tick(); chk("t1_addr", state, 1); chk("t1_bus_pc", bus_sel, 2'b01); chk("t1_re_a", mem_re, 1);
    tick(); chk("t1_wait", state, 2); chk("t1_bus_w", bus_sel, 2'b10); chk("t1_re_w", mem_re, 1);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("t1_load", state, 3); chk("t1_bus_l", bus_sel, 2'b10); chk("t1_irld", ir_load, 1); chk("t1_re_l", mem_re, 0);
    tick(); chk("t1_dec", state, 4); chk("t1_bus_d", bus_sel, 2'b00); chk("t1_es", exec_start, 1); chk("t1_irld_d", ir_load, 0);
    tick(); chk("t1_exec0", state, 5); chk("t1_bus_e", bus_sel, 2'b11); chk("t1_es_off", exec_start, 0);
    chk("t1_pc_idle", pc_inc, 0);
    tick(); chk("t1_exec1", state, 5);
    tick(); chk("t1_exec2", state, 5);
    exec_done = 1'b1; #1;
    chk("t1_pcinc", pc_inc, 1);
    tick(); exec_done = 1'b0;
    chk("t1_next_addr", state, 1);
    chk("t1_n_ir", n_ir - b_ir, 1); chk("t1_n_pc", n_pc - b_pc, 1); chk("t1_n_es", n_es - b_es, 1);

    // Halt opcode: no exec_start, no pc_inc; run=0 leaves
    snap();
    tick(); chk("t2_wait", state, 2);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0; opcode = 4'hF;
    chk("t2_load", state, 3);
    tick(); chk("t2_dec", state, 4); chk("t2_no_es", exec_start, 0);
    tick(); chk("t2_halt", state, 6); chk("t2_halted", halted, 1); chk("t2_bus", bus_sel, 2'b00);
    exec_done = 1'b1;
    tick(); exec_done = 1'b0;
    chk("t2_halt_hold", state, 6);
    chk("t2_n_pc", n_pc - b_pc, 0); chk("t2_n_es", n_es - b_es, 0); chk("t2_n_ir", n_ir - b_ir, 1);
    run = 1'b0;
    tick(); chk("t2_idle", state, 0); chk("t2_unhalt", halted, 0);

    // Timeout: 15 WAIT cycles without ack -> ERR, sticky
    opcode = 4'h1; run = 1'b1;
    tick(); chk("t3_addr", state, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      if (state != 3'd2) chk("t3_wait_run", state, 2);
    end
    chk("t3_wait15", state, 2);
    tick(); chk("t3_err", state, 7); chk("t3_ferr", fetch_err, 1); chk("t3_re", mem_re, 0); chk("t3_bus", bus_sel, 0);
    run = 1'b0; mem_ack = 1'b1;
    tick(); tick(); mem_ack = 1'b0;
    chk("t3_sticky", fetch_err, 1); chk("t3_err_hold", state, 7);
    #2 reset = 1'b0; #1;
    chk("t3_clr_ferr", fetch_err, 0); chk("t3_clr_state", state, 0);
    tick(); reset = 1'b1;

    // Ack on the final WAIT cycle wins; run dropped mid-fetch completes to IDLE
    snap();
    run = 1'b1;
    tick(); chk("t4_addr", state, 1);
    tick(); run = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("t4_wait15", state, 2);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    chk("t4_load", state, 3); chk("t4_no_err", fetch_err, 0);
    tick(); chk("t4_dec", state, 4);
    tick(); chk("t4_exec", state, 5);
    exec_done = 1'b1; #1;
    chk("t5_pcinc", pc_inc, 1);
    tick(); exec_done = 1'b0;
    chk("t5_idle", state, 0);
    tick(); chk("t5_idle_hold", state, 0);
    chk("t5_n_pc", n_pc - b_pc, 1);

    // Async reset in EXEC between edges
    run = 1'b1;
    tick(); tick(); mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick(); tick();
    chk("t6_exec", state, 5);
    snap();
    #2 exec_done = 1'b1; reset = 1'b0; #1;
    chk("t6_state", state, 0); chk("t6_bus", bus_sel, 0); chk("t6_pc", pc_inc, 0);
    chk("t6_outs", {mem_re, ir_load, exec_start, halted, fetch_err}, 0);
    tick(); tick();
    chk("t6_n_pc", n_pc - b_pc, 0); chk("t6_n_ir", n_ir - b_ir, 0);
    exec_done = 1'b0; reset = 1'b1;
    run = 1'b0;
    tick(); chk("t6_idle", state, 0);
`else
    // Single step: two pulses -> exactly two instructions, back to IDLE each time
    snap();
    run = 1'b1;
    tick(); chk("ss_idle_no_step", state, 0);
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      tick(); step = 1'b0;
      chk("ss_addr", state, 1);
      tick(); mem_ack = 1'b1;
      tick(); mem_ack = 1'b0;
      chk("ss_load", state, 3);
      tick(); tick();
      chk("ss_exec", state, 5);
      exec_done = 1'b1;
      tick(); exec_done = 1'b0;
      chk("ss_idle", state, 0);
      tick(); chk("ss_idle_hold", state, 0);
    end
    chk("ss_n_ir", n_ir - b_ir, 2); chk("ss_n_pc", n_pc - b_pc, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
